// File: rtl/fp_sdiv_pkg.sv
// Shared types and helpers for the signed fixed-point divider.
// Optional feature macro: FP_SDIV_DIVZERO_CHECK_EN (see std_fp_sdiv_pipe).
package fp_sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One restoring iteration per quotient bit of (dividend << frac_width).
    function automatic int iter_count(input int width, input int frac_width);
        return width + frac_width;
    endfunction

endpackage

// File: rtl/std_fp_udiv_core.sv
// Unsigned restoring divider: divides (dividend_mag << FRAC_WIDTH) by
// divisor_mag, one quotient bit per clock. valid pulses for one cycle after
// the final iteration; start reloads the core, abort stops it quietly.
module std_fp_udiv_core
    import fp_sdiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend_mag,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] quot_mag,
    output logic [WIDTH-1:0] rem_mag,
    output logic             valid
);

    localparam int N  = iter_count(WIDTH, FRAC_WIDTH);
    localparam int CW = $clog2(N + 1);

    // num_q starts as the shifted dividend; quotient bits enter at the bottom
    // as dividend bits leave the top, so after N steps it holds the quotient.
    logic [N-1:0]     num_q, num_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   partial;
    logic             fits;

    // Next-state: load on start, otherwise one restoring step while busy.
    always_comb begin
        num_d   = num_q;
        rem_d   = rem_q;
        div_d   = div_q;
        count_d = count_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        partial = {rem_q, num_q[N-1]};
        fits    = (partial >= {1'b0, div_q});
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            num_d   = {dividend_mag, {FRAC_WIDTH{1'b0}}};
            rem_d   = '0;
            div_d   = divisor_mag;
            count_d = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            // When the divisor fits, the difference is below 2^WIDTH, so the
            // low bits of a WIDTH-wide subtraction are exact.
            if (fits) begin
                rem_d = partial[WIDTH-1:0] - div_q;
                num_d = {num_q[N-2:0], 1'b1};
            end else begin
                rem_d = partial[WIDTH-1:0];
                num_d = {num_q[N-2:0], 1'b0};
            end
            count_d = count_q + 1'b1;
            if (count_q == CW'(N - 1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            num_q   <= num_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign quot_mag = num_q[WIDTH-1:0];
    assign rem_mag  = rem_q;
    assign valid    = valid_q;

endmodule

// File: rtl/std_fp_sdiv_pipe.sv
// Signed fixed-point divider: sign-magnitude wrapper around std_fp_udiv_core.
// Owns the IDLE/RUN/DONE handshake, sign fix-up and the output registers.
// Define FP_SDIV_DIVZERO_CHECK_EN to short-circuit division by zero into a
// saturated quotient one cycle after start.
module std_fp_sdiv_pipe
    import fp_sdiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);

    // If the split is inconsistent, trust the integer width to define the fraction.
    localparam int FW = (INT_WIDTH + FRAC_WIDTH == WIDTH) ? FRAC_WIDTH : WIDTH - INT_WIDTH;

    state_t           state_q, state_d;
    logic             lneg_q, lneg_d;
    logic             qneg_q, qneg_d;
    logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
    logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
`ifdef FP_SDIV_DIVZERO_CHECK_EN
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] left_q, left_d;
`endif

    logic [WIDTH-1:0] left_mag, right_mag;
    logic [WIDTH-1:0] core_quot, core_rem;
    logic             core_valid, core_start, core_abort;
    logic [WIDTH-1:0] quot_signed, rem_signed;

    // Magnitudes come straight from the inputs: the core latches them on the start edge.
    assign left_mag    = left[WIDTH-1]  ? -left  : left;
    assign right_mag   = right[WIDTH-1] ? -right : right;
    assign quot_signed = qneg_q ? -core_quot : core_quot;
    assign rem_signed  = lneg_q ? -core_rem  : core_rem;

    std_fp_udiv_core #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FW)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .start        (core_start),
        .abort        (core_abort),
        .dividend_mag (left_mag),
        .divisor_mag  (right_mag),
        .quot_mag     (core_quot),
        .rem_mag      (core_rem),
        .valid        (core_valid)
    );

    // Next-state, core control and output-register updates.
    always_comb begin
        state_d         = state_q;
        lneg_d          = lneg_q;
        qneg_d          = qneg_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        core_start      = 1'b0;
        core_abort      = 1'b0;
`ifdef FP_SDIV_DIVZERO_CHECK_EN
        dz_d            = dz_q;
        left_d          = left_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                    lneg_d  = left[WIDTH-1];
                    qneg_d  = left[WIDTH-1] ^ right[WIDTH-1];
`ifdef FP_SDIV_DIVZERO_CHECK_EN
                    dz_d       = (right == '0);
                    left_d     = left;
                    core_start = (right != '0);
`else
                    core_start = 1'b1;
`endif
                end
            end
            RUN: begin
                if (!go) begin
                    state_d    = IDLE;
                    core_abort = 1'b1;
                end
`ifdef FP_SDIV_DIVZERO_CHECK_EN
                else if (dz_q) begin
                    state_d         = DONE;
                    out_quotient_d  = lneg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    out_remainder_d = left_q;
                end
`endif
                else if (core_valid) begin
                    state_d         = DONE;
                    out_quotient_d  = quot_signed;
                    out_remainder_d = rem_signed;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            lneg_q          <= 1'b0;
            qneg_q          <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
`ifdef FP_SDIV_DIVZERO_CHECK_EN
            dz_q            <= 1'b0;
            left_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            lneg_q          <= lneg_d;
            qneg_q          <= qneg_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
`ifdef FP_SDIV_DIVZERO_CHECK_EN
            dz_q            <= dz_d;
            left_q          <= left_d;
`endif
        end
    end

    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_std_fp_sdiv_pipe.sv
// Scoreboard bench for std_fp_sdiv_pipe (WIDTH=32, Q16.16, N=48).
module tb_std_fp_sdiv_pipe;

    localparam int LAT = 49;

    logic        clk;
    logic        reset;
    logic        go;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        done;

    std_fp_sdiv_pipe #(
        .WIDTH      (32),
        .INT_WIDTH  (16),
        .FRAC_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .done          (done)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", out_quotient, e.q);
                    chk("remainder", out_remainder, e.r);
                    chk("done_cycle", 32'(cyc), 32'(e.at));
                    $display("txn: q=%08h r=%08h at cycle %0d", out_quotient, out_remainder, cyc);
                end
            end
        end
    end

    // Called on a negedge; returns on the negedge where done is seen.
    task automatic wait_done();
        int n = 0;
        while (!done && n < 150) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done: got no done expected done within 150 cycles");
        end
    endtask

    // Issue one operation, scramble operands after the start edge, wait for done.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int lat);
        int e0;
        @(negedge clk);
        left  = a;
        right = b;
        go    = 1'b1;
        e0    = cyc + 1;
        sb.push_back('{eq, er, e0 + lat});
        @(negedge clk);
        left  = $urandom;
        right = $urandom;
        wait_done();
        go = 1'b0;
    endtask

    logic [31:0] va[10] = '{32'h00060000, 32'hFFF88000, 32'h00010000, 32'hFFFF0000, 32'h80000000,
                            32'h00008000, 32'h00000007, 32'hFFFFFFF9, 32'h00000000, 32'h00060000};
    logic [31:0] vb[10] = '{32'h00020000, 32'h00020000, 32'h00030000, 32'h00030000, 32'hFFFF0000,
                            32'hFFFFC000, 32'h00020000, 32'h00020000, 32'h00050000, 32'h00020000};
    logic [31:0] vq[10] = '{32'h00030000, 32'hFFFC4000, 32'h00005555, 32'hFFFFAAAB, 32'h80000000,
                            32'hFFFE0000, 32'h00000003, 32'hFFFFFFFD, 32'h00000000, 32'h00030000};
    logic [31:0] vr[10] = '{32'h00000000, 32'h00000000, 32'h00010000, 32'hFFFF0000, 32'h00000000,
                            32'h00000000, 32'h00010000, 32'hFFFF0000, 32'h00000000, 32'h00000000};

    initial begin
        int e0;
        reset = 1'b1;
        go    = 1'b0;
        left  = '0;
        right = '0;
        repeat (3) @(negedge clk);
        chk("reset_quotient", out_quotient, 32'h0);
        chk("reset_remainder", out_remainder, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        reset = 1'b0;

        // Divide by zero first, then the directed table (ends on 6.0/2.0).
`ifdef FP_SDIV_DIVZERO_CHECK_EN
        do_op(32'h00050000, 32'h0, 32'h7FFFFFFF, 32'h00050000, 1);
        do_op(32'hFFFB0000, 32'h0, 32'h80000000, 32'hFFFB0000, 1);
`else
        do_op(32'h00050000, 32'h0, 32'hFFFFFFFF, 32'h00000000, LAT);
`endif
        // go held through done: a second op starts with the operands present then.
        @(negedge clk);
        left  = 32'hFFFA0000;
        right = 32'hFFFE0000;
        go    = 1'b1;
        e0    = cyc + 1;
        sb.push_back('{32'h00030000, 32'h0, e0 + LAT});
        wait_done();
        left  = 32'h00010000;
        right = 32'h00030000;
        sb.push_back('{32'h00005555, 32'h00010000, cyc + 2 + LAT});
        @(negedge clk);
        wait_done();
        go = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(va[i], vb[i], vq[i], vr[i], LAT);
        end

        // Abort: go drops after E0+10; outputs must keep the 6.0/2.0 result.
        @(negedge clk);
        left  = 32'h00010000;
        right = 32'h00030000;
        go    = 1'b1;
        e0    = cyc + 1;
        while (cyc < e0 + 10) @(negedge clk);
        go = 1'b0;
        repeat (70) @(negedge clk);
        chk("abort_quotient", out_quotient, 32'h00030000);
        chk("abort_remainder", out_remainder, 32'h0);

        // Reset at E0+20 of a second run clears outputs at once and no done follows.
        go = 1'b1;
        e0 = cyc + 1;
        while (cyc < e0 + 20) @(negedge clk);
        reset = 1'b1;
        go    = 1'b0;
        #1;
        chk("midrun_reset_quotient", out_quotient, 32'h0);
        chk("midrun_reset_remainder", out_remainder, 32'h0);
        chk("midrun_reset_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (70) @(negedge clk);
        chk("post_reset_quotient", out_quotient, 32'h0);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/std_fp_sdiv_pipe.md
STD_FP_SDIV_PIPE -- requirements
Module: std_fp_sdiv_pipe

Interface
REQ-001 Parameter WIDTH, default 32, total operand/result width in bits.
REQ-002 Parameter INT_WIDTH, default 16, integer bits (two's complement, sign included).
REQ-003 Parameter FRAC_WIDTH, default 16, fraction bits; WIDTH = INT_WIDTH + FRAC_WIDTH SHALL hold.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 go  in  1  start/hold request; held high by the caller until done.
REQ-007 left  in  WIDTH  signed fixed-point dividend.
REQ-008 right  in  WIDTH  signed fixed-point divisor.
REQ-009 out_quotient  out  WIDTH  signed fixed-point quotient, registered.
REQ-010 out_remainder  out  WIDTH  signed remainder, registered.
REQ-011 done  out  1  single-cycle completion pulse.

Function
REQ-012 Quotient SHALL equal trunc-toward-zero((left << FRAC_WIDTH) / right), low WIDTH bits kept.
REQ-013 Remainder SHALL equal (left << FRAC_WIDTH) - quotient*right, with the dividend's sign, magnitude < |right|.
REQ-014 Datapath SHALL be sign-magnitude: operands converted to unsigned magnitudes, N = WIDTH+FRAC_WIDTH restoring iterations (one quotient bit per cycle), sign fixed up on output.
REQ-015 Quotient sign SHALL be left[WIDTH-1] XOR right[WIDTH-1]; a zero magnitude is output as zero.
REQ-016 FSM states: IDLE, RUN, DONE; IDLE->RUN when go sampled high (operands latched); RUN->DONE after N iterations; DONE->IDLE unconditionally.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE, i.e. after edge E0+N+1 where E0 is the edge sampling go in IDLE.
REQ-018 Outputs SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-019 go low during RUN SHALL abort to IDLE with no done and outputs unchanged.
REQ-020 left/right changes after E0 SHALL NOT affect the running operation.
REQ-021 go still high in IDLE after DONE SHALL start a new operation with the current operands.
REQ-022 Overflow (e.g. MIN/-1.0) SHALL yield the truncated low WIDTH bits, with no flag.

Reset
REQ-023 reset asserted SHALL force IDLE, iteration counter 0, out_quotient 0, out_remainder 0, done 0, immediately, independent of clk.
REQ-024 Reset mid-RUN SHALL discard the operation; no done follows deassertion.

Configuration
REQ-025 Macro FP_SDIV_DIVZERO_CHECK_EN defined: right == 0 SHALL be detected at E0, skip RUN, reach DONE one cycle later (done after E0+1), and produce quotient = max positive (0x7FF..F) if left >= 0 else min negative (0x80..0), remainder = left.
REQ-026 Macro undefined: right == 0 SHALL run the full N iterations, giving quotient magnitude all-ones (low WIDTH bits), sign-corrected per REQ-015, remainder per the algorithm.

Structure
REQ-027 Package fp_sdiv_pkg SHALL hold the state enum (IDLE, RUN, DONE) and an iteration-count function of WIDTH and FRAC_WIDTH.
REQ-028 Unsigned iterative core SHALL be sub-module std_fp_udiv_core (start, magnitudes in; quotient/remainder magnitude and valid out); std_fp_sdiv_pipe owns sign handling, FSM and output registers.

Verification (WIDTH=32, INT_WIDTH=16, FRAC_WIDTH=16, N=48)
REQ-029 left=0x00060000 (6.0), right=0x00020000 (2.0), go held -> done once after edge E0+49, quotient 0x00030000, remainder 0.
REQ-030 left=0xFFF88000 (-7.5), right=0x00020000 (2.0) -> quotient 0xFFFC4000 (-3.75), remainder 0.
REQ-031 left=0x00010000 (1.0), right=0x00030000 (3.0) -> quotient 0x00005555, remainder 0x00010000; left negated -> quotient 0xFFFFAAAB, remainder 0xFFFF0000.
REQ-032 Start 6.0/2.0, drop go at E0+10 -> no done, outputs keep prior values; reset at E0+20 of a second run -> all outputs 0 immediately, no done.
REQ-033 left=0x00050000, right=0: with FP_SDIV_DIVZERO_CHECK_EN -> done after E0+1, quotient 0x7FFFFFFF, remainder 0x00050000; without -> done after E0+49, quotient 0xFFFFFFFF.
REQ-034 left=0x80000000, right=0xFFFF0000 (-1.0) -> quotient 0x80000000 (truncated overflow), remainder 0.
